vga_dither_ctrl: RTL

Sequencer for the VGA PWM dither datapath: generates the 2-bit dither phase and an enable that the 24-to-18-bit PWM stage compares against the discarded low colour bits. It tracks line and frame sync and offers four dither patterns (off, horizontal, spatial, temporal). Mode changes are committed only at frame boundaries, so the pattern never changes mid-frame. It sits between the video timing source and the PWM stage in the VGA output path.

---
 rtl/vga_dither_pkg.sv | 33 +++
 rtl/vga_sync_edge.sv | 21 ++
 rtl/vga_dither_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_dither_pkg.sv
// Shared types and helpers for the VGA PWM dither sequencer.
package vga_dither_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        HORIZ    = 2'd1,
        SPATIAL  = 2'd2,
        TEMPORAL = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [1:0] PHASE_IDLE = 2'd3;

    // Per-line starting offset of the dither pattern; sums wrap modulo 4.
    function automatic logic [1:0] dither_offset(input mode_t    mode,
                                                 input logic [1:0] line_cnt,
                                                 input logic [1:0] frame_cnt);
        logic [1:0] off;
        off = '0;
        case (mode)
            SPATIAL:  off = line_cnt;
            TEMPORAL: off = line_cnt + frame_cnt;
            default:  off = '0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Single-register rising-edge detector for a sync strobe.
module vga_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic rise
);

    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_in;
        end
    end

    assign rise = sync_in & ~sync_q;

endmodule

// File: rtl/vga_dither_ctrl.sv
// Dither phase sequencer: tracks line/frame sync, counts pixels and commits
// mode changes only at frame boundaries.
import vga_dither_pkg::*;

module vga_dither_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       csync_en,
    input  logic       hsync,
    input  logic       csync,
    input  logic       vsync,
    input  logic [1:0] mode_req,
    input  logic       mode_we,
    output logic [1:0] phase,
    output logic       dither_en,
    output logic [1:0] mode_cur,
    output logic       mode_pending
);

    logic       lsync;
    logic       l_rise;
    logic       v_rise;
    state_t     state;
    logic [1:0] pix_cnt;
    logic [1:0] line_cnt;
    logic [1:0] frame_cnt;
    mode_t      mode_cur_q;
    mode_t      mode_pend;

    assign lsync    = csync_en ? csync : hsync;
    assign mode_cur = mode_cur_q;

    vga_sync_edge u_lsync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sync_in (lsync),
        .rise    (l_rise)
    );

    vga_sync_edge u_vsync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sync_in (vsync),
        .rise    (v_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= UNLOCK;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            frame_cnt    <= '0;
            mode_cur_q   <= OFF;
            mode_pend    <= OFF;
            mode_pending <= 1'b0;
            phase        <= PHASE_IDLE;
            dither_en    <= 1'b0;
        end else begin
            case (state)
                UNLOCK:  if (v_rise) state <= SYNC;
                SYNC:    if (!lsync) state <= ACTIVE;
                ACTIVE:  if (l_rise) state <= SYNC;
                default: state <= UNLOCK;
            endcase

            if (state == ACTIVE) begin
                if (ce_pix) pix_cnt <= pix_cnt + 2'd1;
            end else begin
                pix_cnt <= '0;
            end

            if (v_rise) begin
                line_cnt  <= '0;
                frame_cnt <= frame_cnt + 2'd1;
            end else if (l_rise) begin
                line_cnt <= line_cnt + 2'd1;
            end

            // A write landing on the frame edge bypasses the pending register.
            if (v_rise && mode_we) begin
                mode_cur_q   <= mode_t'(mode_req);
                mode_pending <= 1'b0;
            end else if (v_rise && mode_pending) begin
                mode_cur_q   <= mode_pend;
                mode_pending <= 1'b0;
            end else if (mode_we) begin
                mode_pend    <= mode_t'(mode_req);
                mode_pending <= 1'b1;
            end

            if (state == ACTIVE && mode_cur_q != OFF) begin
                if (ce_pix) begin
                    phase     <= pix_cnt + dither_offset(mode_cur_q, line_cnt, frame_cnt);
                    dither_en <= 1'b1;
                end
            end else begin
                phase     <= PHASE_IDLE;
                dither_en <= 1'b0;
            end
        end
    end

endmodule
